// File: rtl/sim_video_capture.sv
// Active-area pixel capture into a FWFT FIFO with frame geometry and frame counter.
// Optional per-frame CRC-16-CCITT over pushed pixels when SIM_CAPTURE_CRC_EN is defined.
module sim_video_capture #(
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int HCNT_W     = 12,
  parameter int VCNT_W     = 11,
  parameter int FCNT_W     = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce_pix,
  input  logic                   hblank,
  input  logic                   vblank,
  input  logic [COLOR_W-1:0]     r,
  input  logic [COLOR_W-1:0]     g,
  input  logic [COLOR_W-1:0]     b,
  output logic                   px_valid,
  input  logic                   px_ready,
  output logic [3*COLOR_W+1:0]   px_data,
  output logic [HCNT_W-1:0]      frame_width,
  output logic [VCNT_W-1:0]      frame_height,
  output logic [FCNT_W-1:0]      frame_count,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [15:0]            frame_crc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 3 * COLOR_W;
  localparam int DW = PW + 2;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    CAPTURE   = 2'd1,
    DROP      = 2'd2
  } state_t;

  state_t state, state_nx;

  logic hb_q, vb_q;
  logic h_rise, h_fall, v_rise, v_fall, active;
  logic cap_en, push_try, push, drop_evt, pop, frame_end;
  logic sof_pend, sol_pend, sof_bit, sol_bit;
  logic [AW:0] wptr, rptr;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic full, empty;
  logic [HCNT_W-1:0] lcnt, lmax;
  logic [VCNT_W-1:0] vcnt;
  logic [PW-1:0] rgb;

  assign rgb    = {r, g, b};
  assign active = ce_pix & ~hblank & ~vblank;
  assign h_rise = ce_pix & ~hb_q & hblank;
  assign h_fall = ce_pix & hb_q & ~hblank;
  assign v_rise = ce_pix & ~vb_q & vblank;
  assign v_fall = ce_pix & vb_q & ~vblank;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  assign px_valid = ~empty;
  assign px_data  = empty ? '0 : mem[rptr[AW-1:0]];

  // Blank levels seen on the previous pixel-enable cycle, for edge detection
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hb_q <= 1'b0;
      vb_q <= 1'b0;
    end else if (ce_pix) begin
      hb_q <= hblank;
      vb_q <= vblank;
    end
  end

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= SYNC_WAIT;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      SYNC_WAIT: begin
        if (drop_evt)    state_nx = DROP;
        else if (v_fall) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (drop_evt)    state_nx = DROP;
        else if (v_rise) state_nx = SYNC_WAIT;
      end
      DROP: begin
        if (v_rise) state_nx = SYNC_WAIT;
      end
      default: state_nx = SYNC_WAIT;
    endcase
  end

  // Per-cycle control: capture window also covers the vblank-falling pixel
  always_comb begin
    cap_en    = (state == CAPTURE) |
                ((state == SYNC_WAIT) & v_fall);
    push_try  = cap_en & active;
    push      = push_try & ~full;
    drop_evt  = push_try & full;
    frame_end = (state == CAPTURE) & v_rise;
    pop       = ~empty & px_ready;
    sof_bit   = sof_pend | v_fall;
    sol_bit   = sol_pend | v_fall | h_fall;
  end

  // FIFO pointers; fullness is judged before this cycle's pop
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= (AW+1)'(wptr + 1);
      if (pop)  rptr <= (AW+1)'(rptr + 1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk_sys) begin
    if (push) mem[wptr[AW-1:0]] <= {sof_bit, sol_bit, rgb};
  end

  // Pending start-of-frame / start-of-line tags, consumed by the next pixel
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sof_pend <= 1'b0;
      sol_pend <= 1'b0;
    end else begin
      if (push_try)    sof_pend <= 1'b0;
      else if (v_fall) sof_pend <= 1'b1;
      if (push_try)             sol_pend <= 1'b0;
      else if (v_fall | h_fall) sol_pend <= 1'b1;
    end
  end

  // Line and frame geometry counters
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lcnt <= '0;
      lmax <= '0;
      vcnt <= '0;
    end else if (state != CAPTURE) begin
      lcnt <= push ? HCNT_W'(1) : '0;
      lmax <= '0;
      vcnt <= '0;
    end else if (frame_end) begin
      lcnt <= '0;
      lmax <= '0;
      vcnt <= '0;
    end else if (h_rise) begin
      lcnt <= '0;
      if (lcnt != '0) begin
        if (lcnt > lmax) lmax <= lcnt;
        if (vcnt != '1)  vcnt <= VCNT_W'(vcnt + 1);
      end
    end else if (push && lcnt != '1) begin
      lcnt <= HCNT_W'(lcnt + 1);
    end
  end

  // Frame statistics latched at the end of a cleanly captured frame
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      frame_width  <= '0;
      frame_height <= '0;
      frame_count  <= '0;
    end else if (frame_end) begin
      frame_width  <= lmax;
      frame_height <= vcnt;
      frame_count  <= FCNT_W'(frame_count + 1);
    end
  end

  // Sticky overflow; a new drop beats a clear in the same cycle
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (drop_evt)     overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef SIM_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_upd(
    input logic [15:0]   c,
    input logic [PW-1:0] d
  );
    logic [15:0] x;
    x = c;
    for (int i = PW - 1; i >= 0; i--) begin
      x = {x[14:0], 1'b0} ^ ((x[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return x;
  endfunction

  logic [15:0] crc_run;

  // Running CRC reseeded by the frame's first pixel, published at frame end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else begin
      if (push)
        crc_run <= crc_upd(sof_bit ? 16'hFFFF : crc_run, rgb);
      if (frame_end)
        frame_crc <= crc_run;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_sim_video_capture.sv
// Directed bench for sim_video_capture: capture order, tags, geometry,
// overflow/drop, reset mid-line and frame CRC.
module tb_sim_video_capture;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic        hblank = 1'b1;
  logic        vblank = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        px_valid;
  logic        px_ready = 1'b0;
  logic [25:0] px_data;
  logic [11:0] frame_width;
  logic [10:0] frame_height;
  logic [15:0] frame_count;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic [15:0] frame_crc;

  int nchk = 0;
  int errs = 0;
  int got  = 0;
  int npx  = 0;
  logic [25:0] exp_q [$];
  logic [15:0] crc_exp;

  sim_video_capture dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_pix       (ce_pix),
    .hblank       (hblank),
    .vblank       (vblank),
    .r            (r),
    .g            (g),
    .b            (b),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_data      (px_data),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .frame_count  (frame_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .frame_crc    (frame_crc)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [23:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Host side: every pop is checked against the scoreboard
  always @(negedge clk_sys) begin
    if (px_valid && px_ready) begin
      got++;
      if (exp_q.size() != 0)
        chk("px", 32'(px_data), 32'(exp_q.pop_front()));
    end
  end

  // One pixel-enable step: ce_pix high for one of two clocks
  task automatic step(input logic hb, input logic vb,
                      input logic [23:0] rgb);
    @(posedge clk_sys); #1;
    ce_pix = 1'b1;
    hblank = hb;
    vblank = vb;
    {r, g, b} = rgb;
    @(posedge clk_sys); #1;
    ce_pix = 1'b0;
  endtask

  task automatic act_line(input int w, input logic [7:0] tag,
                          input int y, input bit cap, input int lim);
    logic [23:0] rgb;
    for (int x = 0; x < w; x++) begin
      rgb = {tag, 8'(y), 8'(x)};
      if (cap && npx < lim)
        exp_q.push_back({npx == 0, x == 0, rgb});
      npx++;
      step(1'b0, 1'b0, rgb);
    end
  endtask

  task automatic frame(input int lead, input int w, input int h,
                       input logic [7:0] tag, input bit cap,
                       input int lim);
    npx = 0;
    for (int i = 0; i < lead; i++) step(1'b1, 1'b1, 24'h0);
    if (h == 0) step(1'b1, 1'b0, 24'h0);
    for (int y = 0; y < h; y++) begin
      step(1'b1, 1'b0, 24'h0);
      act_line(w, tag, y, cap, lim);
      step(1'b1, 1'b0, 24'h0);
    end
    step(1'b1, 1'b1, 24'h0);
  endtask

  task automatic drain(input int need);
    int k;
    k = 0;
    px_ready = 1'b1;
    while (px_valid && k < 200) begin
      @(posedge clk_sys); #1;
      k++;
    end
    repeat (2) @(posedge clk_sys);
    #1;
    chk("drain_tmo", 32'(k < 200), 32'd1);
    chk("drain_cnt", 32'(got), 32'(need));
    chk("drain_q", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
`ifdef SIM_CAPTURE_CRC_EN
    crc_exp = crc_ref(24'h000000);
`else
    crc_exp = 16'h0000;
`endif
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    chk("rst_valid", 32'(px_valid), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_crc", 32'(frame_crc), 32'd0);

    // Three 4x3 frames; the first starts mid-frame and is lost
    px_ready = 1'b1;
    got = 0;
    frame(0, 4, 3, 8'h10, 1'b0, 0);
    frame(2, 4, 3, 8'h11, 1'b1, 99);
    frame(2, 4, 3, 8'h12, 1'b1, 99);
    drain(24);
    chk("t1_width", 32'(frame_width), 32'd4);
    chk("t1_height", 32'(frame_height), 32'd3);
    chk("t1_count", 32'(frame_count), 32'd2);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // 20-pixel frame with host stalled: 16 kept, rest dropped
    px_ready = 1'b0;
    got = 0;
    frame(2, 5, 4, 8'h20, 1'b1, 16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count", 32'(frame_count), 32'd2);
    chk("t2_width", 32'(frame_width), 32'd4);
    chk("t2_valid", 32'(px_valid), 32'd1);
    drain(16);
    got = 0;
    frame(2, 3, 2, 8'h21, 1'b1, 99);
    drain(6);
    chk("t2_width2", 32'(frame_width), 32'd3);
    chk("t2_height2", 32'(frame_height), 32'd2);
    chk("t2_count2", 32'(frame_count), 32'd3);
    chk("t2_ovf2", 32'(overflow), 32'd1);

    // Clear alone
    @(posedge clk_sys); #1 overflow_clr = 1'b1;
    @(posedge clk_sys); #1 overflow_clr = 1'b0;
    chk("t4_clr", 32'(overflow), 32'd0);

    // Full FIFO, pop and clear coincide with the 17th pixel
    px_ready = 1'b0;
    got = 0;
    npx = 0;
    step(1'b1, 1'b1, 24'h0);
    step(1'b1, 1'b1, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    act_line(16, 8'h30, 0, 1'b1, 16);
    @(posedge clk_sys); #1;
    ce_pix = 1'b1;
    hblank = 1'b0;
    vblank = 1'b0;
    {r, g, b} = 24'h30_00_10;
    px_ready = 1'b1;
    overflow_clr = 1'b1;
    @(posedge clk_sys); #1;
    ce_pix = 1'b0;
    px_ready = 1'b0;
    overflow_clr = 1'b0;
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_popped", 32'(got), 32'd1);
    chk("t3_head", 32'(px_data), 32'(exp_q[0]));
    step(1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b1, 24'h0);
    chk("t3_count", 32'(frame_count), 32'd3);
    chk("t3_width", 32'(frame_width), 32'd3);
    drain(16);

    // Reset in the middle of a line
    px_ready = 1'b0;
    got = 0;
    npx = 0;
    step(1'b1, 1'b1, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    act_line(2, 8'h40, 0, 1'b1, 99);
    @(posedge clk_sys); #1 reset = 1'b1;
    #1;
    chk("t5_valid", 32'(px_valid), 32'd0);
    chk("t5_data", 32'(px_data), 32'd0);
    chk("t5_width", 32'(frame_width), 32'd0);
    chk("t5_height", 32'(frame_height), 32'd0);
    chk("t5_count", 32'(frame_count), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    @(posedge clk_sys); #1 reset = 1'b0;
    exp_q.delete();
    act_line(2, 8'h41, 0, 1'b0, 0);
    step(1'b1, 1'b0, 24'h0);
    act_line(2, 8'h41, 1, 1'b0, 0);
    step(1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b1, 24'h0);
    chk("t5_novalid", 32'(px_valid), 32'd0);
    px_ready = 1'b1;
    frame(2, 2, 1, 8'h42, 1'b1, 99);
    drain(2);
    chk("t5_count2", 32'(frame_count), 32'd1);
    chk("t5_width2", 32'(frame_width), 32'd2);

    // Single black pixel frame, then a frame with no active lines
    got = 0;
    frame(2, 1, 1, 8'h00, 1'b1, 99);
    drain(1);
    chk("t6_crc", 32'(frame_crc), 32'(crc_exp));
    chk("t6_width", 32'(frame_width), 32'd1);
    chk("t6_height", 32'(frame_height), 32'd1);
    got = 0;
    frame(2, 0, 0, 8'h00, 1'b1, 99);
    drain(0);
    chk("t7_width", 32'(frame_width), 32'd0);
    chk("t7_height", 32'(frame_height), 32'd0);
    chk("t7_count", 32'(frame_count), 32'd3);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
